dp_bram_1clk: RTL

//   Parametrised single-clock true dual-port block RAM with per-lane write enables, selectable write mode,

---
 rtl/dp_bram_1clk.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/dp_bram_1clk.sv
// Single-clock true dual-port RAM with lane write enables, selectable same-port
// read-during-write behaviour, optional output register and post-reset array clear.
module dp_bram_1clk #(
    parameter int                DATA_W       = 36,
    parameter int                LANE_W       = 9,
    parameter int                ADDR_W       = 9,
    parameter string             WRITE_MODE   = "READ_FIRST",
    parameter int                OUT_REG      = 0,
    parameter logic [DATA_W-1:0] SSR_VAL      = '0,
    parameter int                CLEAR_ON_RST = 1,
    localparam int               NL           = DATA_W / LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy,
    output logic              coll,
    output logic              dbg_state_o,
    input  logic              ena,
    input  logic [NL-1:0]     wea,
    input  logic              ssra,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dia,
    output logic [DATA_W-1:0] doa,
    input  logic              enb,
    input  logic [NL-1:0]     web,
    input  logic              ssrb,
    input  logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] dib,
    output logic [DATA_W-1:0] dob
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int MODE_RF = 0;
    localparam int MODE_WF = 1;
    localparam int MODE_NC = 2;
    localparam int MODE    = (WRITE_MODE == "WRITE_FIRST") ? MODE_WF :
                             (WRITE_MODE == "NO_CHANGE")   ? MODE_NC : MODE_RF;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   rd_a, rd_b;
    logic [DATA_W-1:0]   da_q, da_d, db_q, db_d;
    logic                acc_a, acc_b;
    logic [NL-1:0]       wa_eff, wb_eff;
    logic                coll_q, coll_d;

    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [NL-1:0]     we);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < NL; i++) begin
            if (we[i]) r[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
        end
        return r;
    endfunction

    // Data-stage value for an enabled access; hold_w is the current stage content.
    function automatic logic [DATA_W-1:0] stage_next(input logic [DATA_W-1:0] hold_w,
                                                     input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] di,
                                                     input logic [NL-1:0]     we,
                                                     input logic              ssr);
        logic [DATA_W-1:0] r;
        if (ssr) begin
            r = SSR_VAL;
        end else begin
            case (MODE)
                MODE_WF: r = lane_merge(old_w, di, we);
                MODE_NC: r = (we != '0) ? hold_w : old_w;
                default: r = old_w;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) state_d = ST_READY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign init_busy   = (state_q == ST_CLEAR);
    assign dbg_state_o = state_q;

    assign acc_a  = (state_q == ST_READY) && ena;
    assign acc_b  = (state_q == ST_READY) && enb;
    assign wa_eff = acc_a ? wea : '0;
    assign wb_eff = acc_b ? web : '0;

    // Port A lanes are assigned last so A wins on overlapping lanes of one address.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clr_addr_q] <= '0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (wb_eff[i]) mem_q[addrb][i*LANE_W +: LANE_W] <= dib[i*LANE_W +: LANE_W];
            end
            for (int i = 0; i < NL; i++) begin
                if (wa_eff[i]) mem_q[addra][i*LANE_W +: LANE_W] <= dia[i*LANE_W +: LANE_W];
            end
        end
    end

    assign rd_a = mem_q[addra];
    assign rd_b = mem_q[addrb];

    always_comb begin
        da_d = da_q;
        db_d = db_q;
        if (acc_a) da_d = stage_next(da_q, rd_a, dia, wea, ssra);
        if (acc_b) db_d = stage_next(db_q, rd_b, dib, web, ssrb);
    end

    assign coll_d = acc_a && acc_b && (addra == addrb) && ((wea & web) != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            da_q   <= '0;
            db_q   <= '0;
            coll_q <= 1'b0;
        end else begin
            da_q   <= da_d;
            db_q   <= db_d;
            coll_q <= coll_d;
        end
    end

    assign coll = coll_q;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              en_dly_a_q, en_dly_b_q;
            logic [DATA_W-1:0] oa_q, ob_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    en_dly_a_q <= 1'b0;
                    en_dly_b_q <= 1'b0;
                    oa_q       <= '0;
                    ob_q       <= '0;
                end else begin
                    en_dly_a_q <= acc_a;
                    en_dly_b_q <= acc_b;
                    if (en_dly_a_q) oa_q <= da_q;
                    if (en_dly_b_q) ob_q <= db_q;
                end
            end

            assign doa = oa_q;
            assign dob = ob_q;
        end else begin : g_no_out_reg
            assign doa = da_q;
            assign dob = db_q;
        end
    endgenerate

endmodule
